// File: rtl/bus_arb_mux.sv
// Single-entry registered arbiter/mux: selects one valid input channel (explicit
// select or round-robin) and loads it into an output register with valid/ready.
module bus_arb_mux #(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int SW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SW-1:0]             sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SW-1:0]             out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned NCH = CHANNELS;

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SW-1:0]       out_chan_q, out_chan_d;
    logic                out_valid_q, out_valid_d;
    logic [SW-1:0]       last_q, last_d;

    logic                load_en;
    logic                grant_valid;
    logic [SW-1:0]       grant_idx;
    logic [CHANNELS-1:0] grant_oh;
    logic [WIDTH-1:0]    grant_data;

    assign load_en = !out_valid_q || out_ready;

    // Grant selection. Round-robin searches last+1, last+2, ... with wrap;
    // the first valid hit wins.
    always_comb begin
        int unsigned idx_w;
        logic [SW-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx_w       = 0;
        idx         = '0;
        if (MODE == 0) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SW'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NCH; k++) begin
                idx_w = (32'(last_q) + k) % NCH;
                idx   = SW'(idx_w);
                if (!grant_valid && in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx;
                end
            end
        end
    end

    always_comb begin
        grant_oh   = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            grant_oh[i] = grant_valid && (grant_idx == SW'(i));
            if (grant_oh[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is gated by reset so nothing appears accepted while the register is held clear.
    assign in_ready = (load_en && !rst) ? grant_oh : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        last_d      = last_q;
        if (load_en) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = grant_data;
                out_chan_d = grant_idx;
                last_d     = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            last_q      <= SW'(CHANNELS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/bus_arb_mux.md
BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, meaning data bits per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning number of input channels (2..16).
REQ-003 The block SHALL have parameter MODE, default 0, meaning arbitration mode: 0 = explicit select, 1 = round-robin.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port in_data, input, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port in_valid, input, CHANNELS bits: per-channel data valid.
REQ-009 The block SHALL have port in_ready, output, CHANNELS bits: per-channel accept strobe.
REQ-010 The block SHALL have port sel, input, SW = max(1,$clog2(CHANNELS)) bits: channel select, used only when MODE=0.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: registered selected data.
REQ-012 The block SHALL have port out_chan, output, SW bits: index of the channel that supplied out_data.
REQ-013 The block SHALL have port out_valid, output, 1 bit: output register holds a word.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.

Function
REQ-015 The block SHALL hold a single-entry output register (out_data, out_chan, out_valid).
REQ-016 Load enable SHALL be load_en = !out_valid || out_ready (empty, or draining this cycle).
REQ-017 MODE=0: the granted channel SHALL be sel when in_valid[sel]=1; there SHALL be no grant otherwise; sel >= CHANNELS SHALL grant nothing.
REQ-018 MODE=1: the granted channel SHALL be the first valid channel searched from (last+1) mod CHANNELS upward with wrap-around, where last is the index of the most recent transfer.
REQ-019 in_ready SHALL be combinational: in_ready[g] = load_en for the granted channel g, and 0 for all other bits; at most one bit SHALL be high.
REQ-020 A transfer SHALL occur on a clock edge where in_valid[g] && in_ready[g]; out_data SHALL take in_data of channel g, out_chan SHALL take g, and out_valid SHALL go to 1 on the next cycle (latency 1).
REQ-021 When load_en=1 and no grant exists, out_valid SHALL go to 0 at the edge; out_data and out_chan SHALL hold their values.
REQ-022 When load_en=0 (out_valid=1, out_ready=0), all output registers SHALL hold and all in_ready bits SHALL be 0.
REQ-023 Simultaneous drain and fill (out_valid=1, out_ready=1, grant present) SHALL replace the word in the same edge with no bubble, sustaining 1 word/cycle.
REQ-024 The register last SHALL update only on a transfer; in MODE=0, last SHALL be maintained but SHALL have no effect.
REQ-025 out_data SHALL never change while out_valid=1 and out_ready=0.
REQ-026 Input data on non-granted channels SHALL have no effect on any output.

Reset
REQ-027 While rst=1, asynchronously: out_valid=0, out_data=0, out_chan=0, last=CHANNELS-1 (channel 0 highest priority after reset), and in_ready SHALL be all 0.
REQ-028 Reset asserted mid-transfer SHALL discard the held word; after rst deasserts, the first transfer SHALL be accepted at the first rising edge.

Verification
REQ-029 MODE=0, WIDTH=9, CHANNELS=4: in_data ch0=9'h001, ch1=9'h002, all valid, out_ready=1, sel=0, then sel=1 -> out_data 9'h001 one cycle after sel=0, 9'h002 one cycle after sel=1; out_chan 0 then 1.
REQ-030 MODE=1: all four channels valid, out_ready=1 held -> out_chan sequence 0,1,2,3,0 on consecutive cycles with out_valid=1 and no bubbles.
REQ-031 MODE=1: only ch2 and ch0 valid, last=2 -> next grant is 0 (wrap), then 2.
REQ-032 Backpressure: out_valid=1, out_ready=0 for 3 cycles while ch1 valid -> in_ready=4'b0000, out_data stable; out_ready=1 -> ch1 word loaded on that edge.
REQ-033 MODE=0, sel=3, in_valid=4'b0111 -> in_ready=0; out_valid falls to 0 after the current word drains.
REQ-034 Assert rst while out_valid=1 -> out_valid=0, out_data=9'h000 immediately without a clock edge; after release in MODE=1 with all valid, the first grant is ch0.
